mips_div: RTL and testbench



---
 rtl/mips_div_pkg.sv | 13 +
 rtl/mips_div_div_step.sv | 21 ++
 rtl/mips_div.sv | 119 +++++++++++
 tb/tb_mips_div.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU unit.
package mips_div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/mips_div_div_step.sv
// One restoring-division iteration: shift the working register left and
// trial-subtract the divisor from its upper half.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH:0]   i_work,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH-1:0] o_work_hi,
    output logic               o_qbit
);

    logic [WIDTH+1:0] w_upper;
    logic [WIDTH+1:0] w_diff;

    // Upper half after the shift, one extra bit wide so the sign of the trial is exact.
    assign w_upper   = i_work[2*WIDTH:WIDTH-1];
    assign w_diff    = w_upper - {2'b00, i_divisor};
    assign o_qbit    = ~w_diff[WIDTH+1];
    assign o_work_hi = {(o_qbit ? w_diff[WIDTH:0] : w_upper[WIDTH:0]), i_work[WIDTH-2:0]};

endmodule

// File: rtl/mips_div.sv
// Iterative radix-2 divider for MIPS DIV/DIVU; result is {HI=remainder, LO=quotient}.
module mips_div
    import mips_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy,
    output logic               stall
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_work;
    logic [WIDTH-1:0]   r_b_abs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic               r_busy;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [2*WIDTH-1:0] w_work_hi;
    logic               w_qbit;
    logic [2*WIDTH:0]   w_next;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
    assign w_b_abs = (signed_div && b[WIDTH-1]) ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_work    (r_work),
        .i_divisor (r_b_abs),
        .o_work_hi (w_work_hi),
        .o_qbit    (w_qbit)
    );

    // Sign fix-up operates on the final iteration's output.
    assign w_next = {w_work_hi, w_qbit};
    assign w_quo  = r_neg_q ? -w_next[WIDTH-1:0] : w_next[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -w_next[2*WIDTH-1:WIDTH] : w_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_b_abs  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (annul) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_work  <= {(WIDTH + 1)'(0), w_a_abs};
                            r_b_abs <= w_b_abs;
                            r_neg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_r <= signed_div & a[WIDTH-1];
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            // Divide by zero: raw dividend in HI, all ones in LO.
                            if (b == '0) begin
                                r_state  <= DONE;
                                r_result <= {a, {WIDTH{1'b1}}};
                                r_ready  <= 1'b1;
                            end else begin
                                r_state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        r_work <= w_next;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_CNT) begin
                            r_state  <= DONE;
                            r_result <= {w_rem, w_quo};
                            r_ready  <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign result = r_result;
    assign ready  = r_ready;
    assign busy   = r_busy;
    assign stall  = start & ~r_ready;

endmodule

// File: tb/tb_mips_div.sv
// Self-checking bench for mips_div: vector table plus scoreboard, with annul and reset sequences.
module tb_mips_div;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;
    logic           stall;

    mips_div #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .busy       (busy),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour from plain SV arithmetic (truncating division).
    function automatic logic [63:0] model(input logic sd, input logic [31:0] ma, input logic [31:0] mb);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
        if (!sd) return {ma % mb, ma / mb};
        if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa  = $signed(ma);
        sbv = $signed(mb);
        q   = sa / sbv;
        r   = sa % sbv;
        return {32'(r), 32'(q)};
    endfunction

    // Called just after a rising edge; start rises here and ready is expected 'lat' edges later.
    task automatic run_op(input string name, input logic sd, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [63:0] exp, input int lat);
        exp_t e;
        int   n;
        bit   seen;
        bit   stall_ok;
        e.res = exp;
        e.lat = lat;
        sb.push_back(e);
        signed_div = sd;
        a          = ia;
        b          = ib;
        start      = 1'b1;
        #1;
        n        = 0;
        seen     = 0;
        stall_ok = 1;
        while (!seen && n < 100) begin
            if (stall !== 1'b1) stall_ok = 0;
            @(posedge clk);
            #1;
            n++;
            seen = (ready === 1'b1);
        end
        e = sb.pop_front();
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: no ready after %0d cycles, expected at %0d", name, n, e.lat);
        end else begin
            check({name, " result"}, result, e.res);
            check({name, " latency"}, 64'(n), 64'(e.lat));
            check({name, " stall before ready"}, 64'(stall_ok), 64'd1);
            check({name, " stall in ready cycle"}, 64'(stall), 64'd0);
            check({name, " busy in ready cycle"}, 64'(busy), 64'd1);
            last_res = e.res;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check({name, " idle busy"}, 64'(busy), 64'd0);
        check({name, " idle ready"}, 64'(ready), 64'd0);
        check({name, " result hold"}, result, last_res);
    endtask

    vec_t tbl[8];

    initial begin
        bit          saw_ready;
        logic        rsd;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{"divu 100/7",   1'b0, 32'd100,       32'd7,         {32'd2,         32'd14},        33};
        tbl[1] = '{"div -7/2",     1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
        tbl[2] = '{"divu fff9/2",  1'b0, 32'hFFFF_FFF9, 32'd2,         {32'd1,         32'h7FFF_FFFC}, 33};
        tbl[3] = '{"div ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0,         32'h8000_0000}, 33};
        tbl[4] = '{"divu 5/0",     1'b0, 32'd5,         32'd0,         {32'd5,         32'hFFFF_FFFF}, 1};
        tbl[5] = '{"div -7/0",     1'b1, 32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1};
        tbl[6] = '{"div 7/-2",     1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD}, 33};
        tbl[7] = '{"div -100/-7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},        33};

        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result, 64'd0);
        check("reset ready", 64'(ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_op(tbl[i].name, tbl[i].sd, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

        for (int i = 0; i < 6; i++) begin
            rsd = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            if (rb == 32'd0) rb = 32'd3;
            run_op("random", rsd, ra, rb, model(rsd, ra, rb), 33);
        end

        // annul during iteration 10 abandons the operation
        signed_div = 1'b0;
        a          = 32'd1000;
        b          = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        a     = 32'd0;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        annul = 1'b0;
        check("annul busy", 64'(busy), 64'd0);
        check("annul ready", 64'(ready), 64'd0);
        check("annul result hold", result, last_res);
        saw_ready = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) saw_ready = 1;
        end
        check("annul no ready", 64'(saw_ready), 64'd0);
        run_op("divu 20/3", 1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 33);

        // annul together with start in IDLE accepts nothing
        signed_div = 1'b0;
        a          = 32'd5;
        b          = 32'd0;
        start      = 1'b1;
        annul      = 1'b1;
        saw_ready  = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1 || busy === 1'b1) saw_ready = 1;
        end
        start = 1'b0;
        annul = 1'b0;
        check("annul+start no accept", 64'(saw_ready), 64'd0);
        check("annul+start result", result, last_res);
        @(posedge clk);
        #1;

        // asynchronous reset mid-CALC
        signed_div = 1'b0;
        a          = 32'd1000;
        b          = 32'd7;
        start      = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst result", result, 64'd0);
        check("async rst ready", 64'(ready), 64'd0);
        check("async rst busy", 64'(busy), 64'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_res = '0;
        run_op("divu 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
